// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with 2-bit saturating counters,
// trained and checked at MEM. Optional statistics counters enabled by `BP_STATS_EN.
module branch_predictor #(
   parameter int ENTRIES = 16
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_pc_if,
   output logic        o_pred_taken,
   output logic [31:0] o_pred_target,
   input  logic        i_update_valid,
   input  logic [31:0] i_pc_mem,
   input  logic [31:0] i_inst_mem,
   input  logic        i_taken_mem,
   input  logic [31:0] i_target_mem,
   input  logic        i_pred_taken_mem,
   input  logic [31:0] i_pred_target_mem,
   output logic        o_flush,
`ifdef BP_STATS_EN
   output logic [31:0] o_br_count,
   output logic [31:0] o_mispred_count,
`endif
   output logic [31:0] o_redirect_pc
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = 30 - IDX_W;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [1:0] CTR_WNT = 2'b01;
   localparam logic [1:0] CTR_WT  = 2'b10;
   localparam logic [1:0] CTR_ST  = 2'b11;

   logic [ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [31:0]        target_q [ENTRIES];
   logic [1:0]         ctr_q    [ENTRIES];

   logic [IDX_W-1:0] if_idx;
   logic [TAG_W-1:0] if_tag;
   logic             if_hit;

   logic [IDX_W-1:0] mem_idx;
   logic [TAG_W-1:0] mem_tag;
   logic [6:0]       mem_opcode;
   logic             is_ctrl;
   logic             is_branch;
   logic             upd_en;
   logic             mem_hit;

   logic             wr_en;
   logic [31:0]      wr_target;
   logic [1:0]       wr_ctr;

   // Low PC bits and the non-opcode instruction bits play no part in prediction.
   logic unused_bits;
   assign unused_bits = ^{i_pc_if[1:0], i_inst_mem[31:7]};

   // Lookup: reads only registered state, so a same-cycle write is not visible.
   assign if_idx        = i_pc_if[IDX_W+1:2];
   assign if_tag        = i_pc_if[31:IDX_W+2];
   assign if_hit        = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
   assign o_pred_taken  = if_hit && ctr_q[if_idx][1];
   assign o_pred_target = o_pred_taken ? target_q[if_idx] : 32'd0;

   assign mem_idx    = i_pc_mem[IDX_W+1:2];
   assign mem_tag    = i_pc_mem[31:IDX_W+2];
   assign mem_opcode = i_inst_mem[6:0];
   assign is_branch  = (mem_opcode == OP_BRANCH);
   assign is_ctrl    = is_branch || (mem_opcode == OP_JAL) || (mem_opcode == OP_JALR);
   assign upd_en     = i_update_valid && is_ctrl;
   assign mem_hit    = valid_q[mem_idx] && (tag_q[mem_idx] == mem_tag);

   assign o_flush = upd_en &&
                    ((i_taken_mem != i_pred_taken_mem) ||
                     (i_taken_mem && (i_target_mem != i_pred_target_mem)));
   assign o_redirect_pc = (o_flush && i_taken_mem) ? i_target_mem : i_pc_mem + 32'd4;

   // NOTE: every variable gets a default before the branches so no latch is inferred.
   always_comb begin
      wr_en     = 1'b0;
      wr_target = target_q[mem_idx];
      wr_ctr    = ctr_q[mem_idx];
      if (upd_en) begin
         if (mem_hit) begin
            wr_en = 1'b1;
            if (i_taken_mem) begin
               wr_target = i_target_mem;
               wr_ctr    = (ctr_q[mem_idx] == CTR_ST) ? CTR_ST : ctr_q[mem_idx] + 2'd1;
            end else begin
               wr_ctr    = (ctr_q[mem_idx] == 2'b00) ? 2'b00 : ctr_q[mem_idx] - 2'd1;
            end
         end else if (i_taken_mem) begin
            wr_en     = 1'b1;
            wr_target = i_target_mem;
            wr_ctr    = is_branch ? CTR_WT : CTR_ST;
         end
      end
   end

   // NOTE: the table is reset entry by entry because lookups depend on valid/ctr
   // right after reset; sequential state uses non-blocking assignments only.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_q <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= CTR_WNT;
         end
      end else if (wr_en) begin
         valid_q[mem_idx]  <= 1'b1;
         tag_q[mem_idx]    <= mem_tag;
         target_q[mem_idx] <= wr_target;
         ctr_q[mem_idx]    <= wr_ctr;
      end
   end

`ifdef BP_STATS_EN
   logic [31:0] br_count_q,      br_count_d;
   logic [31:0] mispred_count_q, mispred_count_d;

   assign br_count_d      = br_count_q + {31'd0, upd_en};
   assign mispred_count_d = mispred_count_q + {31'd0, o_flush};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         br_count_q      <= '0;
         mispred_count_q <= '0;
      end else begin
         br_count_q      <= br_count_d;
         mispred_count_q <= mispred_count_d;
      end
   end

   assign o_br_count      = br_count_q;
   assign o_mispred_count = mispred_count_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES=16); the statistics
// scenario runs only when BP_STATS_EN is defined.
module tb_branch_predictor;

   localparam logic [31:0] INST_BEQ  = 32'h0000_0063;
   localparam logic [31:0] INST_JAL  = 32'h0000_006F;
   localparam logic [31:0] INST_JALR = 32'h0000_0067;
   localparam logic [31:0] INST_ADDI = 32'h0000_0013;

   logic        i_clk;
   logic        i_rst_n;
   logic [31:0] i_pc_if;
   logic        o_pred_taken;
   logic [31:0] o_pred_target;
   logic        i_update_valid;
   logic [31:0] i_pc_mem;
   logic [31:0] i_inst_mem;
   logic        i_taken_mem;
   logic [31:0] i_target_mem;
   logic        i_pred_taken_mem;
   logic [31:0] i_pred_target_mem;
   logic        o_flush;
   logic [31:0] o_redirect_pc;
`ifdef BP_STATS_EN
   logic [31:0] o_br_count;
   logic [31:0] o_mispred_count;
`endif

   int checks = 0;
   int errors = 0;

   branch_predictor #(.ENTRIES(16)) dut (
      .i_clk             (i_clk),
      .i_rst_n           (i_rst_n),
      .i_pc_if           (i_pc_if),
      .o_pred_taken      (o_pred_taken),
      .o_pred_target     (o_pred_target),
      .i_update_valid    (i_update_valid),
      .i_pc_mem          (i_pc_mem),
      .i_inst_mem        (i_inst_mem),
      .i_taken_mem       (i_taken_mem),
      .i_target_mem      (i_target_mem),
      .i_pred_taken_mem  (i_pred_taken_mem),
      .i_pred_target_mem (i_pred_target_mem),
      .o_flush           (o_flush),
`ifdef BP_STATS_EN
      .o_br_count        (o_br_count),
      .o_mispred_count   (o_mispred_count),
`endif
      .o_redirect_pc     (o_redirect_pc)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Waits for the falling edge, then presents one MEM-stage resolution.
   task automatic drive_mem(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                            input logic tk, input logic [31:0] tgt,
                            input logic ptk, input logic [31:0] ptgt);
      @(negedge i_clk);
      i_update_valid    = v;
      i_pc_mem          = pc;
      i_inst_mem        = inst;
      i_taken_mem       = tk;
      i_target_mem      = tgt;
      i_pred_taken_mem  = ptk;
      i_pred_target_mem = ptgt;
      #1;
   endtask

   // Idle MEM stage and a fetch lookup at pc, sampled mid-cycle.
   task automatic lookup(input logic [31:0] pc);
      drive_mem(1'b0, 32'h0, INST_ADDI, 1'b0, 32'h0, 1'b0, 32'h0);
      i_pc_if = pc;
      #1;
   endtask

   task automatic test_reset;
      i_rst_n = 1'b0;
      i_pc_if = 32'h100;
      i_update_valid = 1'b0; i_pc_mem = 32'h0; i_inst_mem = INST_ADDI;
      i_taken_mem = 1'b0; i_target_mem = 32'h0;
      i_pred_taken_mem = 1'b0; i_pred_target_mem = 32'h0;
      repeat (2) @(negedge i_clk);
      #1;
      checks++; if (o_pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken got %0b exp 0", o_pred_taken); end
      checks++; if (o_pred_target !== 32'h0) begin errors++; $display("FAIL reset_pred_target got %h exp 0", o_pred_target); end
      checks++; if (o_flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %0b exp 0", o_flush); end
      i_rst_n = 1'b1;
   endtask

   task automatic test_beq_train;
      // Cold miss, taken: flush to target; same-cycle lookup still sees empty entry.
      drive_mem(1'b1, 32'h100, INST_BEQ, 1'b1, 32'h140, 1'b0, 32'h0);
      i_pc_if = 32'h100; #1;
      checks++; if (o_flush !== 1'b1) begin errors++; $display("FAIL beq_alloc_flush got %0b exp 1", o_flush); end
      checks++; if (o_redirect_pc !== 32'h140) begin errors++; $display("FAIL beq_alloc_redirect got %h exp 140", o_redirect_pc); end
      checks++; if (o_pred_taken !== 1'b0) begin errors++; $display("FAIL beq_no_bypass got %0b exp 0", o_pred_taken); end
      lookup(32'h100);
      checks++; if (o_pred_taken !== 1'b1) begin errors++; $display("FAIL beq_lookup_taken got %0b exp 1", o_pred_taken); end
      checks++; if (o_pred_target !== 32'h140) begin errors++; $display("FAIL beq_lookup_target got %h exp 140", o_pred_target); end
      // Not taken while predicted taken: ctr 10 -> 01, redirect to fall-through.
      drive_mem(1'b1, 32'h100, INST_BEQ, 1'b0, 32'h140, 1'b1, 32'h140);
      checks++; if (o_flush !== 1'b1) begin errors++; $display("FAIL beq_nt_flush got %0b exp 1", o_flush); end
      checks++; if (o_redirect_pc !== 32'h104) begin errors++; $display("FAIL beq_nt_redirect got %h exp 104", o_redirect_pc); end
      lookup(32'h100);
      checks++; if (o_pred_taken !== 1'b0) begin errors++; $display("FAIL beq_weak_nt got %0b exp 0", o_pred_taken); end
      checks++; if (o_pred_target !== 32'h0) begin errors++; $display("FAIL beq_weak_nt_target got %h exp 0", o_pred_target); end
   endtask

   task automatic test_saturation;
      // ctr 01 -> 10 (mispredict), 10 -> 11 (correct), 11 stays 11, then 11 -> 10.
      drive_mem(1'b1, 32'h100, INST_BEQ, 1'b1, 32'h140, 1'b0, 32'h0);
      checks++; if (o_flush !== 1'b1) begin errors++; $display("FAIL sat_up_flush got %0b exp 1", o_flush); end
      drive_mem(1'b1, 32'h100, INST_BEQ, 1'b1, 32'h140, 1'b1, 32'h140);
      checks++; if (o_flush !== 1'b0) begin errors++; $display("FAIL sat_correct_flush got %0b exp 0", o_flush); end
      checks++; if (o_redirect_pc !== 32'h104) begin errors++; $display("FAIL sat_idle_redirect got %h exp 104", o_redirect_pc); end
      drive_mem(1'b1, 32'h100, INST_BEQ, 1'b1, 32'h140, 1'b1, 32'h140);
      drive_mem(1'b1, 32'h100, INST_BEQ, 1'b0, 32'h140, 1'b1, 32'h140);
      lookup(32'h100);
      checks++; if (o_pred_taken !== 1'b1) begin errors++; $display("FAIL sat_still_taken got %0b exp 1", o_pred_taken); end
      // Non-control at MEM and invalid MEM slot never flush nor train.
      drive_mem(1'b1, 32'h100, INST_ADDI, 1'b0, 32'h0, 1'b1, 32'h140);
      checks++; if (o_flush !== 1'b0) begin errors++; $display("FAIL nonctrl_flush got %0b exp 0", o_flush); end
      drive_mem(1'b0, 32'h100, INST_BEQ, 1'b0, 32'h0, 1'b1, 32'h140);
      checks++; if (o_flush !== 1'b0) begin errors++; $display("FAIL invalid_flush got %0b exp 0", o_flush); end
      drive_mem(1'b1, 32'h100, INST_BEQ, 1'b0, 32'h0, 1'b0, 32'h0);
      drive_mem(1'b1, 32'h100, INST_BEQ, 1'b0, 32'h0, 1'b0, 32'h0);
      lookup(32'h100);
      // ctr 10 -> (ignored x2) -> 01 -> 00 by the two real not-taken updates.
      checks++; if (o_pred_taken !== 1'b0) begin errors++; $display("FAIL sat_down got %0b exp 0", o_pred_taken); end
      drive_mem(1'b1, 32'h100, INST_BEQ, 1'b0, 32'h0, 1'b0, 32'h0);
      drive_mem(1'b1, 32'h100, INST_BEQ, 1'b1, 32'h140, 1'b0, 32'h0);
      lookup(32'h100);
      // Saturated at 00, one taken gives only 01.
      checks++; if (o_pred_taken !== 1'b0) begin errors++; $display("FAIL sat_floor got %0b exp 0", o_pred_taken); end
   endtask

   task automatic test_jalr;
      drive_mem(1'b1, 32'h200, INST_JALR, 1'b1, 32'h300, 1'b0, 32'h0);
      checks++; if (o_redirect_pc !== 32'h300) begin errors++; $display("FAIL jalr1_redirect got %h exp 300", o_redirect_pc); end
      lookup(32'h200);
      checks++; if (o_pred_target !== 32'h300) begin errors++; $display("FAIL jalr1_target got %h exp 300", o_pred_target); end
      drive_mem(1'b1, 32'h200, INST_JALR, 1'b1, 32'h380, 1'b1, 32'h300);
      checks++; if (o_flush !== 1'b1) begin errors++; $display("FAIL jalr2_flush got %0b exp 1", o_flush); end
      checks++; if (o_redirect_pc !== 32'h380) begin errors++; $display("FAIL jalr2_redirect got %h exp 380", o_redirect_pc); end
      lookup(32'h200);
      checks++; if (o_pred_target !== 32'h380) begin errors++; $display("FAIL jalr2_target got %h exp 380", o_pred_target); end
      lookup(32'h100);
      checks++; if (o_pred_taken !== 1'b0) begin errors++; $display("FAIL jalr_evicts_alias got %0b exp 0", o_pred_taken); end
   endtask

   task automatic test_alias;
      drive_mem(1'b1, 32'h100, INST_BEQ, 1'b1, 32'h140, 1'b0, 32'h0);
      drive_mem(1'b1, 32'h140, INST_BEQ, 1'b1, 32'h180, 1'b0, 32'h0);
      i_pc_if = 32'h100; #1;
      checks++; if (o_pred_target !== 32'h140) begin errors++; $display("FAIL alias_old_entry got %h exp 140", o_pred_target); end
      lookup(32'h100);
      checks++; if (o_pred_taken !== 1'b0) begin errors++; $display("FAIL alias_evicted got %0b exp 0", o_pred_taken); end
      lookup(32'h140);
      checks++; if (o_pred_target !== 32'h180) begin errors++; $display("FAIL alias_new_target got %h exp 180", o_pred_target); end
   endtask

   task automatic test_alloc_and_wrap;
      // Miss + not taken writes nothing.
      drive_mem(1'b1, 32'h104, INST_BEQ, 1'b0, 32'h0, 1'b0, 32'h0);
      checks++; if (o_flush !== 1'b0) begin errors++; $display("FAIL miss_nt_flush got %0b exp 0", o_flush); end
      drive_mem(1'b1, 32'h104, INST_BEQ, 1'b1, 32'h500, 1'b0, 32'h0);
      drive_mem(1'b1, 32'h104, INST_BEQ, 1'b0, 32'h0, 1'b1, 32'h500);
      lookup(32'h104);
      // Had the earlier not-taken allocated, ctr would differ; B allocates 10 -> 01.
      checks++; if (o_pred_taken !== 1'b0) begin errors++; $display("FAIL b_alloc_ctr got %0b exp 0", o_pred_taken); end
      // JAL allocates strongly taken: one not-taken leaves it predicted taken.
      drive_mem(1'b1, 32'h108, INST_JAL, 1'b1, 32'h400, 1'b0, 32'h0);
      drive_mem(1'b1, 32'h108, INST_JAL, 1'b0, 32'h0, 1'b1, 32'h400);
      lookup(32'h108);
      checks++; if (o_pred_target !== 32'h400) begin errors++; $display("FAIL jal_alloc_ctr got %h exp 400", o_pred_target); end
      drive_mem(1'b1, 32'hFFFF_FFFC, INST_BEQ, 1'b0, 32'h0, 1'b1, 32'h8);
      checks++; if (o_redirect_pc !== 32'h0) begin errors++; $display("FAIL redirect_wrap got %h exp 0", o_redirect_pc); end
   endtask

   task automatic test_reset_mid_update;
      drive_mem(1'b1, 32'h10C, INST_BEQ, 1'b1, 32'h600, 1'b0, 32'h0);
      #1 i_rst_n = 1'b0;
      lookup(32'h10C);
      checks++; if (o_pred_taken !== 1'b0) begin errors++; $display("FAIL rst_discard got %0b exp 0", o_pred_taken); end
      i_rst_n = 1'b1;
      lookup(32'h140);
      checks++; if (o_pred_taken !== 1'b0) begin errors++; $display("FAIL rst_clears_table got %0b exp 0", o_pred_taken); end
   endtask

`ifdef BP_STATS_EN
   task automatic test_stats;
      i_rst_n = 1'b0;
      lookup(32'h0);
      i_rst_n = 1'b1;
      drive_mem(1'b1, 32'h100, INST_BEQ, 1'b0, 32'h0, 1'b0, 32'h0);
      drive_mem(1'b1, 32'h104, INST_BEQ, 1'b0, 32'h0, 1'b0, 32'h0);
      drive_mem(1'b1, 32'h108, INST_BEQ, 1'b1, 32'h200, 1'b0, 32'h0);
      drive_mem(1'b1, 32'h10C, INST_ADDI, 1'b1, 32'h200, 1'b0, 32'h0);
      drive_mem(1'b0, 32'h110, INST_BEQ, 1'b1, 32'h200, 1'b0, 32'h0);
      lookup(32'h0);
      checks++; if (o_br_count !== 32'd3) begin errors++; $display("FAIL stats_br got %0d exp 3", o_br_count); end
      checks++; if (o_mispred_count !== 32'd1) begin errors++; $display("FAIL stats_mispred got %0d exp 1", o_mispred_count); end
      #1 i_rst_n = 1'b0;
      #1;
      checks++; if (o_br_count !== 32'd0) begin errors++; $display("FAIL stats_br_rst got %0d exp 0", o_br_count); end
      checks++; if (o_mispred_count !== 32'd0) begin errors++; $display("FAIL stats_mispred_rst got %0d exp 0", o_mispred_count); end
      i_rst_n = 1'b1;
   endtask
`endif

   initial begin
      test_reset;
      test_beq_train;
      test_saturation;
      test_jalr;
      test_alias;
      test_alloc_and_wrap;
      test_reset_mid_update;
`ifdef BP_STATS_EN
      test_stats;
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
